// File: rtl/req_gnt_rr_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface req_gnt_rr_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [IDW-1:0]   gnt_id;
    logic             timeout;
    logic [15:0]      grant_count;

    modport master (
        output req,
        input  gnt, gnt_valid, gnt_id, timeout, grant_count
    );

    modport slave (
        input  req,
        output gnt, gnt_valid, gnt_id, timeout, grant_count
    );
endinterface

// File: rtl/req_gnt_rr_arbiter.sv
// Round-robin arbiter: selects one requester, grants it after GNT_DELAY cycles,
// and holds the grant until its request drops or MAX_HOLD cycles expire.
module req_gnt_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int GNT_DELAY = 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic                clk,
    input  logic                rst,
    req_gnt_rr_arbiter_if.slave bus
);
    localparam int             IDW        = $clog2(N_REQ);
    localparam logic [IDW-1:0] LAST_RST   = IDW'(N_REQ - 1);
    localparam logic [3:0]     DLY_LOAD   = 4'(GNT_DELAY - 1);
    localparam logic [7:0]     HOLD_MAX   = 8'(MAX_HOLD);
    localparam bit             DIRECT_GNT = (GNT_DELAY == 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      grant_count_q, grant_count_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [3:0]       dly_cnt_q, dly_cnt_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [IDW-1:0]   winner_s;

    // Scanning downward leaves the lowest offset from last+1 as the final winner.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   l);
        logic [IDW-1:0] w;
        int             idx;
        w = l;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(l) + k) % N_REQ;
            w   = r[idx] ? IDW'(idx) : w;
        end
        return w;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [N_REQ-1:0] v;
        v     = {N_REQ{1'b0}};
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign winner_s = rr_pick(bus.req, last_q);

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        timeout_d     = 1'b0;
        grant_count_d = grant_count_q;
        last_d        = last_q;
        dly_cnt_d     = dly_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    gnt_id_d = winner_s;
                    if (DIRECT_GNT) begin
                        state_d       = GRANT;
                        gnt_d         = onehot(winner_s);
                        hold_cnt_d    = 8'd1;
                        grant_count_d = sat_inc(grant_count_q);
                        last_d        = winner_s;
                    end else begin
                        state_d   = WAIT;
                        dly_cnt_d = DLY_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!bus.req[gnt_id_q]) begin
                    state_d = IDLE;
                end else if (dly_cnt_q == 4'd0) begin
                    state_d       = GRANT;
                    gnt_d         = onehot(gnt_id_q);
                    hold_cnt_d    = 8'd1;
                    grant_count_d = sat_inc(grant_count_q);
                    last_d        = gnt_id_q;
                end else begin
                    dly_cnt_d = dly_cnt_q - 4'd1;
                end
            end
            GRANT: begin
                // A request drop wins over the hold limit, so no timeout in that case.
                if (!bus.req[gnt_id_q]) begin
                    state_d = RELEASE;
                    gnt_d   = {N_REQ{1'b0}};
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d   = RELEASE;
                    gnt_d     = {N_REQ{1'b0}};
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = {N_REQ{1'b0}};
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= {N_REQ{1'b0}};
            gnt_valid_q   <= 1'b0;
            gnt_id_q      <= {IDW{1'b0}};
            timeout_q     <= 1'b0;
            grant_count_q <= 16'd0;
            last_q        <= LAST_RST;
            dly_cnt_q     <= 4'd0;
            hold_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_valid_q   <= gnt_valid_d;
            gnt_id_q      <= gnt_id_d;
            timeout_q     <= timeout_d;
            grant_count_q <= grant_count_d;
            last_q        <= last_d;
            dly_cnt_q     <= dly_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.gnt_valid   = gnt_valid_q;
    assign bus.gnt_id      = gnt_id_q;
    assign bus.timeout     = timeout_q;
    assign bus.grant_count = grant_count_q;
endmodule

// File: tb/tb_req_gnt_rr_arbiter.sv
// Bench for req_gnt_rr_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of the arbitration rules.
module tb_req_gnt_rr_arbiter;
    localparam int N  = 4;
    localparam int MH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    req_gnt_rr_arbiter_if #(.N_REQ(N)) if0 ();
    req_gnt_rr_arbiter_if #(.N_REQ(N)) if1 ();

    req_gnt_rr_arbiter #(.N_REQ(N), .GNT_DELAY(1), .MAX_HOLD(MH)) u0 (
        .clk(clk), .rst(rst), .bus(if0));
    req_gnt_rr_arbiter #(.N_REQ(N), .GNT_DELAY(3), .MAX_HOLD(MH)) u1 (
        .clk(clk), .rst(rst), .bus(if1));

    // reference model state
    int          m_owner, m_held, m_cool, m_last, m_id;
    logic        m_tout;
    logic [15:0] m_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if0.req = 4'b0000;
        if1.req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_cool = 0; m_last = N - 1; m_id = 0;
        m_tout = 1'b0; m_cnt = 16'd0;
    endtask

    // One clock edge of the arbiter with GNT_DELAY=1, given the sampled request vector.
    task automatic model_step(input logic [N-1:0] r);
        int  w;
        bit  found;
        m_tout = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1; m_cool = 1;
            end else if (m_held == MH) begin
                m_owner = -1; m_cool = 1; m_tout = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 4'b0000) begin
            found = 1'b0; w = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && r[(m_last + k) % N]) begin
                    w = (m_last + k) % N; found = 1'b1;
                end
            end
            m_owner = w; m_held = 1; m_last = w; m_id = w;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic test_reset();
        if0.req = 4'b1111;
        tick();
        do_reset();
        checks++;
        if (if0.gnt !== 4'b0000 || if0.gnt_valid !== 1'b0 || if0.gnt_id !== 2'd0 ||
            if0.timeout !== 1'b0 || if0.grant_count !== 16'd0) begin
            errors++;
            $display("FAIL reset: gnt=%b valid=%b id=%0d tout=%b cnt=%0d, expected all zero",
                     if0.gnt, if0.gnt_valid, if0.gnt_id, if0.timeout, if0.grant_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        if0.req = 4'b0001;
        tick();
        checks++;
        if (if0.gnt !== 4'b0001 || if0.gnt_valid !== 1'b1 || if0.gnt_id !== 2'd0 ||
            if0.grant_count !== 16'd1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b valid=%b id=%0d cnt=%0d, expected 0001 1 0 1",
                     if0.gnt, if0.gnt_valid, if0.gnt_id, if0.grant_count);
        end
        repeat (3) tick();
        checks++;
        if (if0.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_hold: gnt=%b expected 0001", if0.gnt);
        end
        if0.req = 4'b0000;
        tick();
        checks++;
        if (if0.gnt !== 4'b0000 || if0.gnt_valid !== 1'b0 || if0.timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_release: gnt=%b valid=%b tout=%b expected 0000 0 0",
                     if0.gnt, if0.gnt_valid, if0.timeout);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        do_reset();
        if0.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8 && !if0.gnt_valid; c++) tick();
            exp_g = 4'b0001 << (g % N);
            checks++;
            if (if0.gnt !== exp_g || if0.gnt_id !== 2'(g % N)) begin
                errors++;
                $display("FAIL rr_order[%0d]: gnt=%b id=%0d expected %b id=%0d",
                         g, if0.gnt, if0.gnt_id, exp_g, g % N);
            end
            if0.req = 4'b1111 & ~exp_g;
            tick();
            if0.req = 4'b1111;
        end
        checks++;
        if (if0.grant_count !== 16'd5) begin
            errors++;
            $display("FAIL rr_count: got %0d expected 5", if0.grant_count);
        end
    endtask

    task automatic test_timeout();
        int hi;
        do_reset();
        if0.req = 4'b1010;
        tick();
        hi = 0;
        for (int c = 0; c < 40 && if0.gnt === 4'b0010; c++) begin
            hi++;
            tick();
        end
        checks++;
        if (hi != MH || if0.gnt !== 4'b0000 || if0.timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_width: high=%0d gnt=%b tout=%b expected %0d 0000 1",
                     hi, if0.gnt, if0.timeout, MH);
        end
        tick();
        checks++;
        if (if0.timeout !== 1'b0 || if0.gnt !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_pulse: tout=%b gnt=%b expected 0 0000", if0.timeout, if0.gnt);
        end
        tick();
        checks++;
        if (if0.gnt !== 4'b1000 || if0.gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL timeout_next: gnt=%b id=%0d expected 1000 3", if0.gnt, if0.gnt_id);
        end
    endtask

    task automatic test_simul_drop();
        do_reset();
        if0.req = 4'b0001;
        tick();
        repeat (MH - 1) tick();
        checks++;
        if (if0.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL drop_pre: gnt=%b expected 0001", if0.gnt);
        end
        if0.req = 4'b0000;
        tick();
        checks++;
        if (if0.gnt !== 4'b0000 || if0.timeout !== 1'b0) begin
            errors++;
            $display("FAIL drop_at_limit: gnt=%b tout=%b expected 0000 0", if0.gnt, if0.timeout);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        if0.req = 4'b1111;
        tick();
        if0.req = 4'b1110;
        tick();
        if0.req = 4'b1111;
        for (int c = 0; c < 8 && !if0.gnt_valid; c++) tick();
        checks++;
        if (if0.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_pre: gnt=%b expected 0010", if0.gnt);
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (if0.gnt !== 4'b0000 || if0.gnt_valid !== 1'b0 || if0.gnt_id !== 2'd0 ||
            if0.timeout !== 1'b0 || if0.grant_count !== 16'd0) begin
            errors++;
            $display("FAIL midrst_out: gnt=%b valid=%b id=%0d tout=%b cnt=%0d expected zeros",
                     if0.gnt, if0.gnt_valid, if0.gnt_id, if0.timeout, if0.grant_count);
        end
        tick();
        checks++;
        if (if0.gnt !== 4'b0001 || if0.gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_first: gnt=%b id=%0d expected 0001 0", if0.gnt, if0.gnt_id);
        end
    endtask

    task automatic test_abort_wait();
        bit seen;
        do_reset();
        if1.req = 4'b0100;
        repeat (2) tick();
        if1.req = 4'b0000;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (if1.gnt !== 4'b0000 || if1.grant_count !== 16'd0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen || if1.gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL abort_nogrant: grant_seen=%b id=%0d cnt=%0d expected 0 2 0",
                     seen, if1.gnt_id, if1.grant_count);
        end
        if1.req = 4'b1111;
        for (int c = 0; c < 10 && !if1.gnt_valid; c++) tick();
        checks++;
        if (if1.gnt !== 4'b0001 || if1.grant_count !== 16'd1) begin
            errors++;
            $display("FAIL abort_after: gnt=%b cnt=%0d expected 0001 1", if1.gnt, if1.grant_count);
        end
        if1.req = 4'b0000;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] exp_g;
        do_reset();
        model_reset();
        r = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
            if0.req = r;
            tick();
            model_step(r);
            exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            checks++;
            if (if0.gnt !== exp_g || if0.gnt_valid !== (m_owner >= 0) ||
                if0.gnt_id !== 2'(m_id) || if0.timeout !== m_tout ||
                if0.grant_count !== m_cnt) begin
                errors++;
                $display("FAIL random[%0d]: gnt=%b v=%b id=%0d to=%b cnt=%0d exp %b %b %0d %b %0d",
                         c, if0.gnt, if0.gnt_valid, if0.gnt_id, if0.timeout, if0.grant_count,
                         exp_g, (m_owner >= 0), m_id, m_tout, m_cnt);
            end
        end
    endtask

    initial begin
        if0.req = 4'b0000;
        if1.req = 4'b0000;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_simul_drop();
        test_reset_mid_grant();
        test_abort_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/req_gnt_rr_arbiter.md
# req_gnt_rr_arbiter

Single-clock round-robin arbiter that produces the `gnt` side of the req/gnt handshake checked by the multi-clock assertion layer. It samples up to `N_REQ` requesters, selects one fairly, and drives a one-hot grant a fixed number of cycles after selection. The grant is held until the winner drops `req` or a hold limit expires. It sits directly upstream of the assertion/checker stage, which consumes `req`/`gnt` pairs.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `GNT_DELAY`, default 1: cycles from the selection edge to `gnt` high, 1..15.
- `MAX_HOLD`, default 16: maximum number of cycles a grant stays high, 2..255.

Ports:
- `clk`, input, 1: single clock. All logic is on `posedge clk`.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, `N_REQ`: request vector, level-sensitive.
- `gnt`, output, `N_REQ`: one-hot or zero grant vector, registered.
- `gnt_valid`, output, 1: OR of `gnt`, registered.
- `gnt_id`, output, `$clog2(N_REQ)`: index of the current or last winner, registered.
- `timeout`, output, 1: one-cycle pulse when a grant is force-released at `MAX_HOLD`.
- `grant_count`, output, 16: number of grants issued, saturating at 16'hFFFF.

## Operation

- Reset (`rst`=1 at an edge): state=IDLE, `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `timeout`=0, `grant_count`=0, round-robin pointer `last`=N_REQ-1, delay and hold counters=0. Reset overrides every other condition, including mid-grant: `gnt` is 0 in the cycle after the reset edge.
- States are IDLE, WAIT, GRANT and RELEASE.
- **IDLE:**
  - If `req`≠0, choose the winner: the first set bit scanning from `last+1` upward, wrapping modulo `N_REQ`.
  - Latch the winner into `gnt_id`, load `dly_cnt`=GNT_DELAY-1, and go to WAIT.
  - If `GNT_DELAY`=1, go directly to GRANT instead, with `gnt` rising at that same edge.
- **WAIT:**
  - If `req[gnt_id]` is 0, abort to IDLE. No grant is issued, `last` is unchanged and `grant_count` is unchanged.
  - Otherwise, if `dly_cnt`=0, go to GRANT: `gnt[gnt_id]`=1, `hold_cnt`=1, `grant_count`+1 (saturating), `last`=`gnt_id`.
  - Otherwise decrement `dly_cnt`.
- **GRANT:** `gnt` stays high.
  - If `req[gnt_id]`=0, go to RELEASE and clear `gnt` at this edge.
  - Else if `hold_cnt`=MAX_HOLD, clear `gnt`, pulse `timeout`=1 for one cycle, and go to RELEASE.
  - Else increment `hold_cnt`.
- **RELEASE:** one mandatory idle cycle with `gnt`=0, then IDLE. Requests are not sampled in RELEASE.
- Requests from non-winners never affect the active grant.
- After a timeout, `last`=winner, so the other requesters have priority next.
- `gnt_valid` equals `|gnt` in the same cycle.
- `gnt_id` holds its value in IDLE and RELEASE.

## Timing

- Grant latency: `req` is sampled high in IDLE at edge E, and `gnt` is high from edge E+GNT_DELAY. With the default `GNT_DELAY`=1 this satisfies `req ##1 gnt`.
- Release latency: `req` is sampled low in GRANT at edge E, and `gnt` is low from edge E. Minimum back-to-back spacing is 2 low cycles on `gnt` between grants (RELEASE plus IDLE selection) when `GNT_DELAY`=1.
- Maximum grant width is exactly `MAX_HOLD` cycles of `gnt`=1.
- `timeout` is high only in the first cycle where `gnt` is low after a forced release.
- Boundaries:
  - Pointer wrap: `last`=N_REQ-1 scans from 0.
  - If all requests are set, the winner is `last+1` mod `N_REQ`.
  - A simultaneous drop of `req` and `hold_cnt`=MAX_HOLD is treated as a normal release: no `timeout`.
  - At `grant_count`=FFFF, the count holds.

## Test plan

- **Single requester:** reset, `req`=4'b0001 held. Expect `gnt`=0001 exactly 1 cycle later, `gnt_id`=0, `grant_count`=1. Drop `req`; `gnt`=0 at that edge.
- **Round-robin:** `req`=4'b1111 held, each grant released by dropping the winner's bit for 1 cycle. Expect grant order 0,1,2,3,0 and `grant_count`=5.
- **Abort in WAIT:** `GNT_DELAY`=3, pulse `req[2]` for 2 cycles. Expect no `gnt`, `grant_count`=0, and the state back in IDLE.
- **Timeout:** `MAX_HOLD`=16, `req[1]` held forever and `req[3]` set. Expect `gnt[1]` high for exactly 16 cycles, a 1-cycle `timeout`, then `gnt[3]` granted next.
- **Reset mid-grant:** assert `rst` during GRANT. Expect all outputs 0 on the next cycle, and after reset the first winner with `req`=1111 is 0.
- **Simultaneous drop at limit:** drop `req` on the cycle where `hold_cnt`=MAX_HOLD. Expect `gnt` to fall and `timeout` to stay 0.
